// File: rtl/board_pkg.sv
// Shared board definitions: tile codes, board geometry and scanner FSM states.
package board_pkg;

  localparam int unsigned BOARD_ADDR_W = 10;

  localparam logic [3:0] TILE_EMPTY  = 4'd0;
  localparam logic [3:0] TILE_WALL   = 4'd1;
  localparam logic [3:0] TILE_PELLET = 4'd2;
  localparam logic [3:0] TILE_POWER  = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/pellet_scanner.sv
// Pellet scanner: walks board RAM once, counts pellet and power tiles,
// then tracks remaining counts as the game logic reports eats.
module pellet_scanner
  import board_pkg::*;
#(
  parameter int ADDR_W = BOARD_ADDR_W,
  parameter int TILE_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [TILE_W-1:0] rd_data,
  input  logic              pellet_eaten,
  input  logic              power_eaten,
  output logic [10:0]       pellets_left,
  output logic [3:0]        power_left,
  output logic              ready,
  output logic              level_clear
);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [10:0]       pel_q, pel_d;
  logic [3:0]        pow_q, pow_d;
  logic              ready_q, ready_d;
  logic              is_pellet, is_power;

  // Classify the tile returned for the address issued one cycle earlier.
  always_comb begin
    is_pellet = valid_q && (rd_data == TILE_W'(TILE_PELLET));
    is_power  = valid_q && (rd_data == TILE_W'(TILE_POWER));
  end

  // Next-state and next-count logic; hold overrides every state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    pel_d   = pel_q;
    pow_d   = pow_q;
    ready_d = ready_q;
    if (hold) begin
      state_d = IDLE;
      addr_d  = '0;
      pel_d   = '0;
      pow_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SCAN;
          addr_d  = '0;
          pel_d   = '0;
          pow_d   = '0;
          ready_d = 1'b0;
        end
        SCAN: begin
          valid_d = 1'b1;
          if (addr_q == '1) state_d = DRAIN;
          else              addr_d  = addr_q + 1'b1;
          if (is_pellet) pel_d = pel_q + 11'd1;
          if (is_power && (pow_q != 4'hF)) pow_d = pow_q + 4'd1;
        end
        DRAIN: begin
          state_d = DONE;
          ready_d = 1'b1;
          if (is_pellet) pel_d = pel_q + 11'd1;
          if (is_power && (pow_q != 4'hF)) pow_d = pow_q + 4'd1;
        end
        DONE: begin
          if (pellet_eaten && (pel_q != '0)) pel_d = pel_q - 11'd1;
          if (power_eaten && (pow_q != '0)) pow_d = pow_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= 1'b0;
      pel_q   <= '0;
      pow_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      pel_q   <= pel_d;
      pow_q   <= pow_d;
      ready_q <= ready_d;
    end
  end

  assign rd_addr      = addr_q;
  assign pellets_left = pel_q;
  assign power_left   = pow_q;
  assign ready        = ready_q;
  assign level_clear  = ready_q && (pel_q == '0) && (pow_q == '0);

endmodule

// File: tb/tb_pellet_scanner.sv
// Directed bench for pellet_scanner with a 1024x4 one-cycle-latency board RAM.
module tb_pellet_scanner;

  logic        clk;
  logic        reset;
  logic        hold;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        pellet_eaten;
  logic        power_eaten;
  logic [10:0] pellets_left;
  logic [3:0]  power_left;
  logic        ready;
  logic        level_clear;

  logic [3:0]  ram [0:1023];
  int          vectors;
  int          miscompares;

  pellet_scanner #(.ADDR_W(10), .TILE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .pellet_eaten (pellet_eaten),
    .power_eaten  (power_eaten),
    .pellets_left (pellets_left),
    .power_left   (power_left),
    .ready        (ready),
    .level_clear  (level_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= ram[rd_addr];

  // Empty/wall background; pellets at multiples of 3 from 0, powers from 1023 down.
  task automatic load_board(input int n_pel, input int n_pow);
    for (int i = 0; i < 1024; i++) ram[i] = (i % 2 == 0) ? 4'd0 : 4'd1;
    for (int i = 0; i < n_pel; i++) ram[i * 3] = 4'd2;
    for (int i = 0; i < n_pow; i++) ram[1023 - i] = 4'd3;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Raise hold, release it, and count edges from SCAN entry until ready.
  task automatic run_scan(input int exp_pel, input int exp_pow, input bit eat_during);
    int cycles;
    bit seen;
    hold = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ready, pellets_left, power_left} !== 16'd0) begin
      miscompares++;
      $display("FAIL hold_clear: got ready=%0b pel=%0d pow=%0d expected 0/0/0",
               ready, pellets_left, power_left);
    end
    repeat (4) @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    vectors++;
    if (rd_addr !== 10'd0) begin
      miscompares++;
      $display("FAIL scan_start_addr: got %0d expected 0", rd_addr);
    end
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 1200) begin
      pellet_eaten = eat_during && (cycles == 0 || cycles == 100 || cycles == 1024);
      power_eaten  = eat_during && (cycles == 500 || cycles == 1024);
      @(posedge clk);
      cycles++;
      @(negedge clk);
      pellet_eaten = 1'b0;
      power_eaten  = 1'b0;
      if (ready) seen = 1'b1;
    end
    vectors++;
    if (cycles !== 1025) begin
      miscompares++;
      $display("FAIL scan_latency: got %0d cycles expected 1025", cycles);
    end
    vectors++;
    if (pellets_left !== 11'(exp_pel)) begin
      miscompares++;
      $display("FAIL scan_pellets: got %0d expected %0d", pellets_left, exp_pel);
    end
    vectors++;
    if (power_left !== 4'(exp_pow)) begin
      miscompares++;
      $display("FAIL scan_power: got %0d expected %0d", power_left, exp_pow);
    end
    vectors++;
    if (level_clear !== ((exp_pel == 0) && (exp_pow == 0))) begin
      miscompares++;
      $display("FAIL scan_level_clear: got %0b expected %0b", level_clear,
               (exp_pel == 0) && (exp_pow == 0));
    end
    vectors++;
    if (rd_addr !== 10'h3FF) begin
      miscompares++;
      $display("FAIL done_addr_hold: got %0d expected 1023", rd_addr);
    end
  endtask

  // Drive one eat pulse for one cycle starting at a falling edge.
  task automatic pulse(input logic pe, input logic pw);
    pellet_eaten = pe;
    power_eaten  = pw;
    @(negedge clk);
    pellet_eaten = 1'b0;
    power_eaten  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    hold  = 1'b1;
    pellet_eaten = 1'b0;
    power_eaten  = 1'b0;
    #1;
    vectors++;
    if ({rd_addr, pellets_left, power_left, ready, level_clear} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got addr=%0d pel=%0d pow=%0d rdy=%0b lc=%0b expected all 0",
               rd_addr, pellets_left, power_left, ready, level_clear);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rd_addr, ready} !== 11'd0) begin
      miscompares++;
      $display("FAIL idle_under_hold: got addr=%0d rdy=%0b expected 0/0", rd_addr, ready);
    end
  endtask

  task automatic test_scan_count;
    load_board(300, 4);
    run_scan(300, 4, 1'b0);
  endtask

  task automatic test_power_sat;
    load_board(0, 20);
    run_scan(0, 15, 1'b0);
  endtask

  task automatic test_eat_clear;
    load_board(2, 1);
    run_scan(2, 1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("eat1_pellets", int'(pellets_left), 1);
    chk("eat1_power", int'(power_left), 1);
    chk("eat1_level_clear", int'(level_clear), 0);
    pulse(1'b1, 1'b1);
    chk("eat2_pellets", int'(pellets_left), 0);
    chk("eat2_power", int'(power_left), 0);
    chk("eat2_level_clear", int'(level_clear), 1);
  endtask

  task automatic test_underflow;
    pulse(1'b1, 1'b0);
    chk("underflow_pellets", int'(pellets_left), 0);
    pulse(1'b0, 1'b1);
    chk("underflow_power", int'(power_left), 0);
    chk("underflow_level_clear", int'(level_clear), 1);
    load_board(300, 4);
    run_scan(300, 4, 1'b1);
  endtask

  task automatic test_abort;
    int guard;
    load_board(300, 4);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    hold  = 1'b0;
    guard = 0;
    while (rd_addr !== 10'd500 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_reached_500", int'(rd_addr), 500);
    chk("abort_partial_pellets", int'(pellets_left), 167);
    hold = 1'b1;
    @(negedge clk);
    chk("abort_addr", int'(rd_addr), 0);
    chk("abort_pellets", int'(pellets_left), 0);
    chk("abort_power", int'(power_left), 0);
    chk("abort_ready", int'(ready), 0);
    run_scan(300, 4, 1'b0);
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_addr", int'(rd_addr), 0);
    chk("async_pellets", int'(pellets_left), 0);
    chk("async_power", int'(power_left), 0);
    chk("async_ready", int'(ready), 0);
    chk("async_level_clear", int'(level_clear), 0);
    hold = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 1024; i++) ram[i] = 4'd0;
    test_reset;
    test_scan_count;
    test_power_sat;
    test_eat_clear;
    test_underflow;
    test_abort;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pellet_scanner.md
PELLET_SCANNER -- requirements
Module: pellet_scanner

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, board RAM address width (1024 tiles).
REQ-002 SHALL have parameter TILE_W, default 4, tile code width.
REQ-003 SHALL have ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- hold  input  1  high while the board-reset writer is overwriting board RAM.
- rd_addr  output  ADDR_W  board RAM read address.
- rd_data  input  TILE_W  board RAM read data, valid one clk after rd_addr.
- pellet_eaten  input  1  single-cycle pulse from game logic.
- power_eaten  input  1  single-cycle pulse from game logic.
- pellets_left  output  11  remaining normal pellets.
- power_left  output  4  remaining power pellets.
- ready  output  1  high when scan is complete and counts are valid.
- level_clear  output  1  high when ready and both counts are zero.

Function
REQ-004 SHALL implement FSM states IDLE, SCAN, DRAIN, DONE.
REQ-005 IDLE: counts held at 0, ready low; when hold is low, go to SCAN with rd_addr=0.
REQ-006 SCAN: rd_addr SHALL increment by 1 each cycle from 0 to 2^ADDR_W-1; after issuing the last address, go to DRAIN.
REQ-007 A one-bit valid pipeline flag SHALL track rd_addr by one cycle, so each rd_data is classified exactly once.
REQ-008 On each valid rd_data, TILE_PELLET SHALL increment pellets_left and TILE_POWER SHALL increment power_left; all other codes SHALL be ignored.
REQ-009 power_left SHALL saturate at 15 during scan; pellets_left cannot overflow (11 bits covers 1024).
REQ-010 DRAIN: classify the final rd_data, then go to DONE; total latency from first SCAN cycle to ready high is 1025 cycles (ADDR_W=10).
REQ-011 DONE: ready high, and rd_addr holds at its last value.
REQ-012 In DONE, pellet_eaten SHALL decrement pellets_left and power_eaten SHALL decrement power_left, each saturating at 0.
REQ-013 Simultaneous pellet_eaten and power_eaten SHALL decrement both counts in the same cycle.
REQ-014 pellet_eaten and power_eaten SHALL be ignored in IDLE, SCAN and DRAIN.
REQ-015 level_clear SHALL be combinational: ready AND pellets_left==0 AND power_left==0.
REQ-016 hold high in any state SHALL, on the next edge, force IDLE, clear both counts and the valid flag, and lower ready (rescan mid-operation).

Reset
REQ-017 reset low SHALL immediately force IDLE, rd_addr=0, pellets_left=0, power_left=0, valid flag=0 and ready=0, independent of clk.
REQ-018 After reset release, behaviour SHALL follow REQ-005 (scan starts on the first edge with hold low).

Structure
REQ-019 Tile codes SHALL live in shared package board_pkg: TILE_EMPTY=0, TILE_WALL=1, TILE_PELLET=2, TILE_POWER=3.
REQ-020 board_pkg SHALL also hold BOARD_ADDR_W=10 and the FSM state enum, shared with the board-reset writer and the renderer.
REQ-021 The module SHALL be a single module with no sub-modules; the board RAM is external.

Verification
REQ-022 The bench SHALL model board RAM as 1024x4 with one-cycle read latency.
REQ-023 The bench SHALL cover these directed scenarios:
- Scan count: RAM has 300 pellet tiles, 4 power tiles, rest walls/empty; hold high 5 cycles, then low -> ready rises exactly 1025 cycles after SCAN entry, pellets_left=300, power_left=4, level_clear=0.
- Power saturation: 20 power tiles -> power_left=15.
- Eat and clear: 2 pellets, 1 power; then pellet_eaten twice and power_eaten once, the last two simultaneous -> counts 1/1, then 0/0, level_clear=1 in the final cycle.
- Underflow and early eats: extra pellet_eaten with pellets_left=0 -> stays 0; pellet_eaten pulses during SCAN -> final count unchanged.
- Mid-scan abort: hold raised at rd_addr=500 -> next cycle IDLE, counts 0, ready 0; hold lowered -> full rescan gives correct totals.
- Async reset: reset asserted mid-DONE between clock edges -> all outputs 0 before the next clk edge.
